// File: rtl/rot_shift_pipe.sv
// Pipelined barrel rotator/shifter: ROTR, ROTL, SHR, SHL, SRA and pass-through,
// with PIPE_STAGES register stages, valid/ready backpressure and an enable freeze.
module rot_shift_pipe #(
  parameter int DATA_WIDTH  = 256,
  parameter int SHAMT_WIDTH = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             mode,
  input  logic [SHAMT_WIDTH-1:0] shift_in,
  input  logic [DATA_WIDTH-1:0]  a_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  a_out,
  output logic                   busy
);

  localparam int LVLS  = $clog2(DATA_WIDTH);
  localparam int BASE  = LVLS / PIPE_STAGES;
  localparam int EXTRA = LVLS % PIPE_STAGES;

  // First mux level handled by stage s; earlier stages absorb the remainder.
  function automatic int lvl_lo(input int s);
    return s * BASE + ((s < EXTRA) ? s : EXTRA);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_level(
    input logic [DATA_WIDTH-1:0] d,
    input logic [2:0]            m,
    input logic                  fill,
    input int                    k
  );
    logic [DATA_WIDTH-1:0] ones;
    logic [DATA_WIDTH-1:0] r;
    int                    sh;
    ones = '1;
    sh   = 1 << k;
    case (m)
      3'b000:  r = (d >> sh) | (d << (DATA_WIDTH - sh));
      3'b001:  r = (d << sh) | (d >> (DATA_WIDTH - sh));
      3'b010:  r = d >> sh;
      3'b011:  r = d << sh;
      3'b100:  r = (d >> sh) | (fill ? ~(ones >> sh) : '0);
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_levels(
    input logic [DATA_WIDTH-1:0] d,
    input logic [2:0]            m,
    input logic                  fill,
    input logic [LVLS-1:0]       amt,
    input int                    lo,
    input int                    hi
  );
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < LVLS; k++) begin
      if (k >= lo && k < hi && amt[k]) r = shift_level(r, m, fill, k);
    end
    return r;
  endfunction

  logic                  stall;
  logic                  advance;
  logic                  ovf;
  logic                  is_shift;
  logic                  is_pass;
  logic [LVLS-1:0]       pre_amt;
  logic [DATA_WIDTH-1:0] pre_data;

  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic                   fill_q [PIPE_STAGES];
  logic                   fill_d [PIPE_STAGES];
  logic [2:0]             mode_q [PIPE_STAGES];
  logic [2:0]             mode_d [PIPE_STAGES];
  logic [LVLS-1:0]        amt_q  [PIPE_STAGES];
  logic [LVLS-1:0]        amt_d  [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  data_q [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  data_d [PIPE_STAGES];

  assign stall     = out_valid & ~out_ready;
  assign advance   = enable & ~stall;
  assign in_ready  = advance;
  assign out_valid = valid_q[PIPE_STAGES-1];
  assign a_out     = data_q[PIPE_STAGES-1];
  assign busy      = |valid_q;

  generate
    if (SHAMT_WIDTH > LVLS) begin : g_ovf
      assign ovf = |shift_in[SHAMT_WIDTH-1:LVLS];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

  assign is_shift = (mode == 3'b010) | (mode == 3'b011) | (mode == 3'b100);
  assign is_pass  = mode[2] & (mode[1] | mode[0]);

  // Out-of-range shifts are resolved up front so the mux levels only see amounts < DATA_WIDTH.
  always_comb begin
    pre_amt  = shift_in[LVLS-1:0];
    pre_data = a_in;
    if (is_pass) begin
      pre_amt = '0;
    end else if (is_shift && ovf) begin
      pre_amt  = '0;
      pre_data = (mode == 3'b100) ? {DATA_WIDTH{a_in[DATA_WIDTH-1]}} : '0;
    end
  end

  generate
    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign valid_d[0] = in_valid & in_ready;
        assign fill_d[0]  = a_in[DATA_WIDTH-1];
        assign mode_d[0]  = mode;
        assign amt_d[0]   = pre_amt;
        assign data_d[0]  = apply_levels(pre_data, mode, a_in[DATA_WIDTH-1], pre_amt,
                                         lvl_lo(0), lvl_lo(1));
      end else begin : g_next
        assign valid_d[gi] = valid_q[gi-1];
        assign fill_d[gi]  = fill_q[gi-1];
        assign mode_d[gi]  = mode_q[gi-1];
        assign amt_d[gi]   = amt_q[gi-1];
        assign data_d[gi]  = apply_levels(data_q[gi-1], mode_q[gi-1], fill_q[gi-1],
                                          amt_q[gi-1], lvl_lo(gi), lvl_lo(gi + 1));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        fill_q[s] <= 1'b0;
        mode_q[s] <= '0;
        amt_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        fill_q[s] <= fill_d[s];
        mode_q[s] <= mode_d[s];
        amt_q[s]  <= amt_d[s];
        data_q[s] <= data_d[s];
      end
    end
  end

endmodule

// File: tb/tb_rot_shift_pipe.sv
// Scoreboard bench for rot_shift_pipe (32-bit, 2 stages): directed cases plus
// randomized traffic checked against a per-bit reference model.
module tb_rot_shift_pipe;

  localparam int DW = 32;
  localparam int SW = 8;
  localparam int PS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    mode;
  logic [SW-1:0] shift_in;
  logic [DW-1:0] a_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] a_out;
  logic          busy;

  rot_shift_pipe #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW), .PIPE_STAGES(PS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .shift_in(shift_in), .a_in(a_in), .out_valid(out_valid),
    .out_ready(out_ready), .a_out(a_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [DW-1:0] exp_q[$];
  bit  b2b_track = 0;
  int  last_pop  = -1;
  bit  rand_on   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: each result bit is picked from the operand by index arithmetic.
  function automatic logic [DW-1:0] ref_model(input logic [DW-1:0] a, input logic [2:0] m,
                                               input int unsigned n);
    logic [DW-1:0] r;
    int unsigned rn;
    rn = n % DW;
    for (int i = 0; i < DW; i++) begin
      case (m)
        3'd0:    r[i] = a[(i + rn) % DW];
        3'd1:    r[i] = a[(i + DW - rn) % DW];
        3'd2:    r[i] = (i + n < DW) ? a[i + n] : 1'b0;
        3'd3:    r[i] = (i >= n) ? a[i - n] : 1'b0;
        3'd4:    r[i] = (i + n < DW) ? a[i + n] : a[DW-1];
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  // Monitor: pops on every output transfer, checks holds across stall/freeze cycles.
  logic          prev_ok = 0, prev_hold = 0, prev_ov = 0;
  logic [DW-1:0] prev_aout = '0;
  always @(negedge clk) begin
    if (rst_n && prev_ok && prev_hold) begin
      chk("hold_valid", {31'd0, out_valid}, {31'd0, prev_ov});
      chk("hold_data", a_out, prev_aout);
    end
    if (rst_n && out_valid && !out_ready) chk("stall_in_ready", {31'd0, in_ready}, '0);
    if (rst_n && out_valid && out_ready && enable) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL spurious_output: got %h expected none (cycle %0d)", a_out, cyc);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        $display("[TB] result %h expected %h cycle %0d", a_out, e, cyc);
        chk("result", a_out, e);
        if (b2b_track) begin
          if (last_pop >= 0) chk("b2b_gap", DW'(cyc - last_pop), DW'(1));
          last_pop = cyc;
        end
      end
    end
    prev_ok   = rst_n;
    prev_hold = !enable || (out_valid && !out_ready);
    prev_ov   = out_valid;
    prev_aout = a_out;
  end

  task automatic issue(input logic [DW-1:0] a, input logic [2:0] m, input logic [SW-1:0] sh,
                       input logic [DW-1:0] exp, output int waited);
    logic acc;
    waited   = 0;
    in_valid = 1'b1;
    a_in     = a;
    mode     = m;
    shift_in = sh;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 300);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL issue_timeout: got no accept expected accept (cycle %0d)", cyc);
    end else begin
      exp_q.push_back(exp);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    int w;
    logic [DW-1:0] one;
    one      = 1;
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode     = '0;
    shift_in = '0;
    a_in     = '0;

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, '0);
    chk("rst_a_out", a_out, '0);
    chk("rst_in_ready", {31'd0, in_ready}, '0);
    chk("rst_busy", {31'd0, busy}, '0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    enable    = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: ROTR 1 by 1, visible exactly two advancing cycles after accept.
    @(posedge clk); #1;
    issue(32'h1, 3'd0, 8'd1, 32'h8000_0000, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early", {31'd0, out_valid}, '0);
    @(negedge clk);
    chk("lat_on_time", {31'd0, out_valid}, 32'd1);
    drain();
    @(posedge clk); #1;
    issue(32'h1, 3'd2, 8'd1, 32'h0, w);
    issue(32'h8000_0000, 3'd4, 8'd4,  32'hF800_0000, w);
    issue(32'h8000_0000, 3'd4, 8'd40, 32'hFFFF_FFFF, w);
    issue(32'h8000_0000, 3'd2, 8'd40, 32'h0, w);
    issue(32'h8000_0000, 3'd0, 8'd36, 32'h0800_0000, w);
    issue(32'hDEAD_BEEF, 3'd3, 8'd0,  32'hDEAD_BEEF, w);
    issue(32'hDEAD_BEEF, 3'd6, 8'd9,  32'hDEAD_BEEF, w);
    issue(32'h1234_5678, 3'd3, 8'd32, 32'h0, w);
    in_valid = 1'b0;
    drain();

    // Back-to-back ROTL 0..7: one result per cycle.
    b2b_track = 1;
    last_pop  = -1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      issue(32'h1, 3'd1, SW'(i), one << i, w);
      chk("b2b_accept_wait", DW'(w), DW'(1));
    end
    in_valid = 1'b0;
    drain();
    b2b_track = 0;

    // Backpressure for 3 cycles while a stream of 4 ops is in flight.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          logic [DW-1:0] a;
          a = $urandom;
          issue(a, 3'd0, SW'(i + 3), ref_model(a, 3'd0, i + 3), w);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Freeze for 2 cycles mid-stream.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] a;
      a = $urandom;
      issue(a, 3'd4, SW'(i * 5), ref_model(a, 3'd4, i * 5), w);
    end
    in_valid = 1'b0;
    enable   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("freeze_in_ready", {31'd0, in_ready}, '0);
      chk("freeze_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    enable = 1'b1;
    drain();

    // Reset mid-stream: in-flight ops are discarded.
    @(posedge clk); #1;
    issue(32'hA5A5_0F0F, 3'd1, 8'd3, 32'h0, w);
    issue(32'h0F0F_A5A5, 3'd0, 8'd7, 32'h0, w);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, '0);
    chk("midrst_busy", {31'd0, busy}, '0);
    chk("midrst_a_out", a_out, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("post_rst_busy", {31'd0, busy}, '0);

    // Randomized traffic with random backpressure and freezes.
    rand_on = 1;
    fork
      while (rand_on) begin
        @(posedge clk); #1;
        if (rand_on) begin
          out_ready = ($urandom_range(0, 3) != 0);
          enable    = ($urandom_range(0, 7) != 0);
        end
      end
    join_none
    @(posedge clk); #1;
    for (int i = 0; i < 200; i++) begin
      logic [DW-1:0] a;
      logic [2:0]    m;
      int unsigned   sh;
      a  = $urandom;
      m  = 3'($urandom_range(0, 7));
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 32);
      issue(a, m, SW'(sh), ref_model(a, m, sh), w);
    end
    in_valid = 1'b0;
    rand_on  = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    enable    = 1'b1;
    drain();
    chk("final_queue_empty", DW'(exp_q.size()), '0);
    chk("final_busy", {31'd0, busy}, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
